// File: rtl/display7seg_mux_n_if.sv
// Host-side bundle for the multiplexed 7-segment driver:
// load request, blanking control, status and display pins.
interface display7seg_mux_n_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 4
);
  logic [WIDTH-1:0]    numero;
  logic                carrega;
  logic                apaga;
  logic                ocupado;
  logic                pronto;
  logic                overflow;
  logic [DIGITS+7:0]   display;

  modport master (
    output numero, carrega, apaga,
    input  ocupado, pronto, overflow, display
  );

  modport slave (
    input  numero, carrega, apaga,
    output ocupado, pronto, overflow, display
  );
endinterface

// File: rtl/display7seg_mux_n.sv
// Latches a binary value, converts it to BCD one bit per clock and
// scans the digits onto an active-low multiplexed 7-segment display.
module display7seg_mux_n #(
  parameter int WIDTH       = 8,
  parameter int DIGITS      = 4,
  parameter int PRESCALE    = 50000,
  parameter bit BLANK_ZEROS = 1'b1
) (
  input logic                clock,
  input logic                zera_as,
  display7seg_mux_n_if.slave bus
);
  localparam int BW = 4 * (WIDTH / 3 + 1);
  localparam int NB = BW / 4;
  localparam int PB = (NB > DIGITS) ? NB : DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int SW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    OCIOSO,
    CONVERTE,
    ATUALIZA
  } state_t;

  state_t                   state_q;
  logic [WIDTH-1:0]         bin_q, bin_d;
  logic [BW-1:0]            bcd_q, bcd_d;
  logic [CW-1:0]            cnt_q;
  logic                     ocupado_q;
  logic                     pronto_q;
  logic                     ovf_q, ovf_d;
  logic [DIGITS-1:0][3:0]   dig_q, dig_d;
  logic [SW-1:0]            pre_q;
  logic [IW-1:0]            idx_q;
  logic [DIGITS+7:0]        disp_q, disp_d;

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  // One shift-add-3 step over the {bcd, bin} pair.
  always_comb begin
    logic [BW-1:0] adj;
    adj = bcd_q;
    for (int i = 0; i < NB; i++) begin
      if (adj[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    bcd_d = {adj[BW-2:0], bin_q[WIDTH-1]};
    bin_d = {bin_q[WIDTH-2:0], 1'b0};
  end

  always_comb begin
    logic [4*PB-1:0] pad;
    pad = '0;
    pad[BW-1:0] = bcd_q;
    for (int i = 0; i < DIGITS; i++)
      dig_d[i] = pad[4*i +: 4];
    ovf_d = |(pad >> (4 * DIGITS));
  end

  // Leading-zero run walks down from the top digit; ones never blank.
  always_comb begin
    logic              lead;
    logic [DIGITS-1:0] blank;
    lead  = 1'b1;
    blank = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      lead     = lead && (dig_q[i] == 4'd0);
      blank[i] = lead && BLANK_ZEROS && !ovf_q;
    end
    disp_d = {{DIGITS{1'b1}}, 8'hFF};
    if (!bus.apaga && !blank[idx_q]) begin
      disp_d[DIGITS+7:8] = ~(DIGITS'(1) << idx_q);
      disp_d[7:0] = ovf_q ? 8'hBF : seg_code(dig_q[idx_q]);
    end
  end

  always_ff @(posedge clock or posedge zera_as) begin
    if (zera_as) begin
      state_q   <= OCIOSO;
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      ocupado_q <= 1'b0;
      pronto_q  <= 1'b0;
      ovf_q     <= 1'b0;
      dig_q     <= '0;
    end else begin
      pronto_q <= 1'b0;
      unique case (state_q)
        OCIOSO: begin
          if (bus.carrega) begin
            bin_q     <= bus.numero;
            bcd_q     <= '0;
            cnt_q     <= '0;
            ocupado_q <= 1'b1;
            state_q   <= CONVERTE;
          end
        end
        CONVERTE: begin
          bin_q <= bin_d;
          bcd_q <= bcd_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1))
            state_q <= ATUALIZA;
        end
        ATUALIZA: begin
          dig_q     <= dig_d;
          ovf_q     <= ovf_d;
          pronto_q  <= 1'b1;
          ocupado_q <= 1'b0;
          state_q   <= OCIOSO;
        end
        default: state_q <= OCIOSO;
      endcase
    end
  end

  always_ff @(posedge clock or posedge zera_as) begin
    if (zera_as) begin
      pre_q  <= '0;
      idx_q  <= '0;
      disp_q <= {{DIGITS{1'b1}}, 8'hFF};
    end else begin
      disp_q <= disp_d;
      if (pre_q == SW'(PRESCALE - 1)) begin
        pre_q <= '0;
        idx_q <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end else begin
        pre_q <= pre_q + 1'b1;
      end
    end
  end

  assign bus.ocupado  = ocupado_q;
  assign bus.pronto   = pronto_q;
  assign bus.overflow = ovf_q;
  assign bus.display  = disp_q;
endmodule

// File: tb/tb_display7seg_mux_n.sv
// Directed bench: three driver instances (8-bit, 8-bit without
// zero blanking, 16-bit), all scanning four digits every 4 clocks.
module tb_display7seg_mux_n;
  logic clk;
  logic zera_as;
  int   checks;
  int   passes;

  display7seg_mux_n_if #(.WIDTH(8),  .DIGITS(4)) i8 ();
  display7seg_mux_n_if #(.WIDTH(8),  .DIGITS(4)) iz ();
  display7seg_mux_n_if #(.WIDTH(16), .DIGITS(4)) i16 ();

  display7seg_mux_n #(
    .WIDTH(8), .DIGITS(4), .PRESCALE(4), .BLANK_ZEROS(1'b1)
  ) u8 (.clock(clk), .zera_as(zera_as), .bus(i8.slave));

  display7seg_mux_n #(
    .WIDTH(8), .DIGITS(4), .PRESCALE(4), .BLANK_ZEROS(1'b0)
  ) uz (.clock(clk), .zera_as(zera_as), .bus(iz.slave));

  display7seg_mux_n #(
    .WIDTH(16), .DIGITS(4), .PRESCALE(4), .BLANK_ZEROS(1'b1)
  ) u16 (.clock(clk), .zera_as(zera_as), .bus(i16.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] seen [3][4];
  bit         on   [3][4];

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Record which digits light up and the last segment code seen on each.
  task automatic observe(int n);
    logic [11:0] d [3];
    for (int s = 0; s < 3; s++)
      for (int j = 0; j < 4; j++) begin
        seen[s][j] = 8'hFF;
        on[s][j]   = 1'b0;
      end
    repeat (n) begin
      @(negedge clk);
      d[0] = i8.display;
      d[1] = iz.display;
      d[2] = i16.display;
      for (int s = 0; s < 3; s++)
        for (int j = 0; j < 4; j++)
          if (!d[s][8+j]) begin
            on[s][j]   = 1'b1;
            seen[s][j] = d[s][7:0];
          end
    end
  endtask

  task automatic load(int s, logic [15:0] v);
    @(negedge clk);
    case (s)
      0: begin i8.numero = v[7:0]; i8.carrega = 1'b1; end
      1: begin iz.numero = v[7:0]; iz.carrega = 1'b1; end
      default: begin i16.numero = v; i16.carrega = 1'b1; end
    endcase
    @(negedge clk);
    i8.carrega  = 1'b0;
    iz.carrega  = 1'b0;
    i16.carrega = 1'b0;
  endtask

  task automatic wait_pronto(string tag, int s, int budget);
    bit got;
    logic p;
    got = 1'b0;
    for (int c = 0; c < budget && !got; c++) begin
      @(negedge clk);
      p = (s == 0) ? i8.pronto : (s == 1) ? iz.pronto : i16.pronto;
      if (p === 1'b1) got = 1'b1;
    end
    check(tag, got, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int         bad;
    int         np;
    bit         found;
    logic [3:0] prev;
    logic [3:0] en;
    logic [11:0] exp_d;

    checks = 0;
    passes = 0;
    zera_as = 1'b1;
    i8.numero = '0;  i8.carrega = 1'b0;  i8.apaga = 1'b0;
    iz.numero = '0;  iz.carrega = 1'b0;  iz.apaga = 1'b0;
    i16.numero = '0; i16.carrega = 1'b0; i16.apaga = 1'b0;

    // 1: reset values, then reset aborting a conversion
    repeat (2) @(negedge clk);
    check("rst_ocupado", i8.ocupado, 1'b0);
    check("rst_pronto", i8.pronto, 1'b0);
    check("rst_overflow", i16.overflow, 1'b0);
    check("rst_display", i8.display, 12'hFFF);
    zera_as = 1'b0;
    @(negedge clk);
    i8.numero = 8'd200;
    i8.carrega = 1'b1;
    @(negedge clk);
    i8.carrega = 1'b0;
    check("t1_busy", i8.ocupado, 1'b1);
    repeat (2) @(negedge clk);
    zera_as = 1'b1;
    #1;
    check("t1_abort_ocupado", i8.ocupado, 1'b0);
    check("t1_abort_display", i8.display, 12'hFFF);
    @(negedge clk);
    zera_as = 1'b0;
    @(negedge clk);
    check("t1_scan_digit0", i8.display, 12'hEC0);
    np = 0;
    repeat (15) begin
      @(negedge clk);
      if (i8.pronto !== 1'b0 || i8.ocupado !== 1'b0) np++;
    end
    check("t1_no_pronto", np, 0);

    // 2: 255, cycle-exact busy/pronto timing
    @(negedge clk);
    i8.numero = 8'd255;
    i8.carrega = 1'b1;
    @(negedge clk);
    i8.carrega = 1'b0;
    check("t2_busy_k", {i8.ocupado, i8.pronto}, 2'b10);
    bad = 0;
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      if (i8.ocupado !== 1'b1 || i8.pronto !== 1'b0) bad++;
    end
    check("t2_busy_hold", bad, 0);
    @(negedge clk);
    check("t2_pronto_k9", {i8.ocupado, i8.pronto}, 2'b01);
    @(negedge clk);
    check("t2_pronto_pulse", i8.pronto, 1'b0);
    observe(20);
    check("t2_d0", seen[0][0], 8'h92);
    check("t2_d1", seen[0][1], 8'h92);
    check("t2_d2", seen[0][2], 8'hA4);
    check("t2_d3_off", on[0][3], 1'b0);
    check("t2_ovf", i8.overflow, 1'b0);

    // 3: zero, with and without leading-zero blanking
    load(0, 16'd0);
    wait_pronto("t3_pronto8", 0, 20);
    load(1, 16'd0);
    wait_pronto("t3_prontoz", 1, 20);
    observe(20);
    check("t3_d0", seen[0][0], 8'hC0);
    check("t3_on8", {on[0][3], on[0][2], on[0][1], on[0][0]}, 4'b0001);
    check("t3_onz", {on[1][3], on[1][2], on[1][1], on[1][0]}, 4'b1111);
    for (int j = 0; j < 4; j++)
      check($sformatf("t3_z_d%0d", j), seen[1][j], 8'hC0);

    // 4: second load during conversion is dropped
    @(negedge clk);
    i8.numero = 8'd255;
    i8.carrega = 1'b1;
    @(negedge clk);
    i8.carrega = 1'b0;
    @(negedge clk);
    i8.numero = 8'd17;
    i8.carrega = 1'b1;
    @(negedge clk);
    i8.carrega = 1'b0;
    np = 0;
    repeat (20) begin
      @(negedge clk);
      if (i8.pronto === 1'b1) np++;
    end
    check("t4_one_pronto", np, 1);
    observe(20);
    check("t4_d0", seen[0][0], 8'h92);
    check("t4_d1", seen[0][1], 8'h92);
    check("t4_d2", seen[0][2], 8'hA4);
    check("t4_d3_off", on[0][3], 1'b0);

    // 5: 16-bit overflow, then 9999
    load(2, 16'd12345);
    wait_pronto("t5_pronto_a", 2, 30);
    @(negedge clk);
    check("t5_ovf_set", i16.overflow, 1'b1);
    observe(20);
    for (int j = 0; j < 4; j++)
      check($sformatf("t5_dash%0d", j), seen[2][j], 8'hBF);
    load(2, 16'd9999);
    wait_pronto("t5_pronto_b", 2, 30);
    @(negedge clk);
    check("t5_ovf_clr", i16.overflow, 1'b0);
    observe(20);
    for (int j = 0; j < 4; j++)
      check($sformatf("t5_nine%0d", j), seen[2][j], 8'h90);

    // 6: scan order/dwell, then apaga window on the 9999 display
    found = 1'b0;
    prev = i16.display[11:8];
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (i16.display[11:8] == 4'hE && prev != 4'hE) found = 1'b1;
      prev = i16.display[11:8];
    end
    check("t6_sync", found, 1'b1);
    for (int p = 0; p < 48; p++) begin
      if (p > 0) @(negedge clk);
      en = 4'b0001 << ((p / 4) % 4);
      exp_d = (p >= 21 && p <= 28) ? 12'hFFF : {~en, 8'h90};
      check($sformatf("t6_scan_p%0d", p), i16.display, exp_d);
      i16.apaga = (p >= 20 && p < 28);
    end
    i16.apaga = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
